// File: rtl/alu_cmd_initiator.sv
// Host-side initiator for the UART ALU command protocol.
// Serializes opcode + two operands into a 12-byte packet on a byte-wide AXI-stream master,
// then gathers a 4-byte little-endian result (or times out) from the RX byte stream.
module alu_cmd_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter int unsigned CNT_W          = 20
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_opcode_i,
    input  logic [31:0] cmd_a_i,
    input  logic [31:0] cmd_b_i,
    output logic [7:0]  m_axis_tdata_o,
    output logic        m_axis_tvalid_o,
    input  logic        m_axis_tready_i,
    input  logic [7:0]  s_axis_tdata_i,
    input  logic        s_axis_tvalid_i,
    output logic        s_axis_tready_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_timeout_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {StIdle, StSend, StWaitRsp} state_e;

    localparam logic [CNT_W-1:0] TmoLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  idx_q, idx_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] tmo_inc;
    logic [23:0] rx_shift_q, rx_shift_d;  // lanes 0..2; lane 3 goes straight to rsp_data
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_timeout_q, rsp_timeout_d;
    logic [7:0]  tx_byte;

    assign tmo_inc = tmo_q + CNT_W'(1);

    // Packet byte selected by the current index from the latched command.
    always_comb begin
        tx_byte = 8'h00;
        case (idx_q)
            4'd0:    tx_byte = opcode_q;
            4'd2:    tx_byte = 8'h0C;
            4'd4:    tx_byte = a_q[7:0];
            4'd5:    tx_byte = a_q[15:8];
            4'd6:    tx_byte = a_q[23:16];
            4'd7:    tx_byte = a_q[31:24];
            4'd8:    tx_byte = b_q[7:0];
            4'd9:    tx_byte = b_q[15:8];
            4'd10:   tx_byte = b_q[23:16];
            4'd11:   tx_byte = b_q[31:24];
            default: tx_byte = 8'h00;
        endcase
    end

    // Next-state logic for the command/response sequencer.
    always_comb begin
        state_d       = state_q;
        opcode_d      = opcode_q;
        a_d           = a_q;
        b_d           = b_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        rx_shift_d    = rx_shift_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    opcode_d = cmd_opcode_i;
                    a_d      = cmd_a_i;
                    b_d      = cmd_b_i;
                    idx_d    = 4'd0;
                    state_d  = StSend;
                end
            end
            StSend: begin
                if (m_axis_tready_i) begin
                    if (idx_q == 4'd11) begin
                        idx_d   = 4'd0;
                        tmo_d   = '0;
                        state_d = StWaitRsp;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            StWaitRsp: begin
                if (s_axis_tvalid_i) begin
                    tmo_d = '0;
                    if (idx_q == 4'd3) begin
                        rsp_data_d    = {s_axis_tdata_i, rx_shift_q};
                        rsp_valid_d   = 1'b1;
                        rsp_timeout_d = 1'b0;
                        idx_d         = 4'd0;
                        state_d       = StIdle;
                    end else begin
                        case (idx_q[1:0])
                            2'd0:    rx_shift_d[7:0]   = s_axis_tdata_i;
                            2'd1:    rx_shift_d[15:8]  = s_axis_tdata_i;
                            default: rx_shift_d[23:16] = s_axis_tdata_i;
                        endcase
                        idx_d = idx_q + 4'd1;
                    end
                end else if (tmo_inc == TmoLast) begin
                    // Responder went silent: abort with a flagged, zeroed response.
                    tmo_d         = '0;
                    rsp_data_d    = '0;
                    rsp_valid_d   = 1'b1;
                    rsp_timeout_d = 1'b1;
                    idx_d         = 4'd0;
                    state_d       = StIdle;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any packet in flight without a response pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            opcode_q      <= '0;
            a_q           <= '0;
            b_q           <= '0;
            idx_q         <= '0;
            tmo_q         <= '0;
            rx_shift_q    <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            a_q           <= a_d;
            b_q           <= b_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            rx_shift_q    <= rx_shift_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready_o     = (state_q == StIdle);
    assign busy_o          = (state_q != StIdle);
    assign m_axis_tvalid_o = (state_q == StSend);
    assign m_axis_tdata_o  = (state_q == StSend) ? tx_byte : 8'h00;
    // Stray RX bytes outside a response window are swallowed to keep the UART from overrunning.
    assign s_axis_tready_o = 1'b1;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_data_o      = rsp_data_q;
    assign rsp_timeout_o   = rsp_timeout_q;

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Self-checking bench for alu_cmd_initiator: transaction-level model plus directed literals.
module tb_alu_cmd_initiator;

    localparam int unsigned T = 16;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cmd_valid_i;
    logic        cmd_ready_o;
    logic [7:0]  cmd_opcode_i;
    logic [31:0] cmd_a_i;
    logic [31:0] cmd_b_i;
    logic [7:0]  m_axis_tdata_o;
    logic        m_axis_tvalid_o;
    logic        m_axis_tready_i;
    logic [7:0]  s_axis_tdata_i;
    logic        s_axis_tvalid_i;
    logic        s_axis_tready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_timeout_o;
    logic        busy_o;

    alu_cmd_initiator #(.TIMEOUT_CYCLES(T), .CNT_W(5)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_opcode_i    (cmd_opcode_i),
        .cmd_a_i         (cmd_a_i),
        .cmd_b_i         (cmd_b_i),
        .m_axis_tdata_o  (m_axis_tdata_o),
        .m_axis_tvalid_o (m_axis_tvalid_o),
        .m_axis_tready_i (m_axis_tready_i),
        .s_axis_tdata_i  (s_axis_tdata_i),
        .s_axis_tvalid_i (s_axis_tvalid_i),
        .s_axis_tready_o (s_axis_tready_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_data_o      (rsp_data_o),
        .rsp_timeout_o   (rsp_timeout_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model state: bytes still owed on TX, response collection, expected response outputs.
    logic [7:0]  tx_q[$];
    bit          m_wait = 0;
    bit          m_busy;
    int          rx_cnt = 0;
    logic [31:0] rx_word = '0;
    int          idle = 0;
    bit          exp_rv = 0;
    logic [31:0] exp_rd = '0;
    bit          exp_rto = 0;
    int          m_sent = 0;

    // Observations used by the directed checks.
    int          cyc = 0;
    int          rsp_count = 0;
    int          rsp_cyc = 0;
    logic [31:0] rsp_seen_data = '0;
    logic        rsp_seen_to = 1'b0;
    int          acc_count = 0;
    int          acc_cyc = 0;
    int          last_rx_cyc = 0;
    logic [7:0]  cap_q[$];
    int          cap_cyc[$];
    bit          tog_mode = 0;

    // Compare DUT against the model every cycle, then advance the model.
    always @(negedge clk) begin
        cyc++;
        if (reset_i) begin
            chk("rst_cmd_ready", 32'(cmd_ready_o), 1);
            chk("rst_tvalid", 32'(m_axis_tvalid_o), 0);
            chk("rst_tdata", 32'(m_axis_tdata_o), 0);
            chk("rst_s_tready", 32'(s_axis_tready_o), 1);
            chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
            chk("rst_rsp_timeout", 32'(rsp_timeout_o), 0);
            chk("rst_rsp_data", rsp_data_o, 0);
            chk("rst_busy", 32'(busy_o), 0);
            tx_q.delete();
            m_wait  = 0;
            exp_rv  = 0;
            exp_rd  = '0;
            exp_rto = 0;
            m_sent  = 0;
        end else begin
            m_busy = (tx_q.size() != 0) || m_wait;
            chk("cmd_ready", 32'(cmd_ready_o), 32'(!m_busy));
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("tvalid", 32'(m_axis_tvalid_o), 32'(tx_q.size() != 0));
            if (tx_q.size() != 0) chk("tdata", 32'(m_axis_tdata_o), 32'(tx_q[0]));
            chk("s_tready", 32'(s_axis_tready_o), 1);
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
            chk("rsp_data", rsp_data_o, exp_rd);
            chk("rsp_timeout", 32'(rsp_timeout_o), 32'(exp_rto));

            if (rsp_valid_o) begin
                rsp_count++;
                rsp_cyc       = cyc;
                rsp_seen_data = rsp_data_o;
                rsp_seen_to   = rsp_timeout_o;
            end
            if (cmd_valid_i && cmd_ready_o) begin
                acc_count++;
                acc_cyc = cyc;
            end
            if (m_axis_tvalid_o && m_axis_tready_i) begin
                cap_q.push_back(m_axis_tdata_o);
                cap_cyc.push_back(cyc);
            end

            exp_rv = 0;
            if (!m_busy) begin
                if (cmd_valid_i) begin
                    tx_q = '{cmd_opcode_i, 8'h00, 8'h0C, 8'h00,
                             cmd_a_i[7:0], cmd_a_i[15:8], cmd_a_i[23:16], cmd_a_i[31:24],
                             cmd_b_i[7:0], cmd_b_i[15:8], cmd_b_i[23:16], cmd_b_i[31:24]};
                    m_sent = 0;
                end
            end else if (tx_q.size() != 0) begin
                if (m_axis_tready_i) begin
                    void'(tx_q.pop_front());
                    m_sent++;
                    if (tx_q.size() == 0) begin
                        m_wait  = 1;
                        rx_cnt  = 0;
                        rx_word = '0;
                        idle    = 0;
                    end
                end
            end else begin
                if (s_axis_tvalid_i) begin
                    rx_word[8*rx_cnt +: 8] = s_axis_tdata_i;
                    rx_cnt++;
                    idle        = 0;
                    last_rx_cyc = cyc;
                    if (rx_cnt == 4) begin
                        exp_rv  = 1;
                        exp_rd  = rx_word;
                        exp_rto = 0;
                        m_wait  = 0;
                    end
                end else begin
                    idle++;
                    if (idle == int'(T) - 1) begin
                        exp_rv  = 1;
                        exp_rd  = '0;
                        exp_rto = 1;
                        m_wait  = 0;
                    end
                end
            end
        end
    end

    // TX back-pressure pattern: always ready, or toggling every cycle.
    initial begin
        m_axis_tready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tog_mode) m_axis_tready_i = ~m_axis_tready_i;
            else          m_axis_tready_i = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                            input bit hold);
        int start;
        int n;
        start        = acc_count;
        n            = 0;
        cmd_opcode_i = op;
        cmd_a_i      = a;
        cmd_b_i      = b;
        cmd_valid_i  = 1'b1;
        do begin
            tick();
            n++;
        end while (acc_count == start && n < 100);
        chk("cmd_accepted", 32'(acc_count != start), 1);
        if (!hold) cmd_valid_i = 1'b0;
    endtask

    task automatic wait_tx_done();
        int n;
        n = 0;
        while (!m_wait && n < 200) begin
            tick();
            n++;
        end
        chk("tx_done", 32'(m_wait), 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        s_axis_tdata_i  = b;
        s_axis_tvalid_i = 1'b1;
        tick();
        s_axis_tvalid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int start);
        int n;
        n = 0;
        while (rsp_count == start && n < 200) begin
            tick();
            n++;
        end
        chk("rsp_seen", 32'(rsp_count != start), 1);
    endtask

    task automatic chk_cap(input string name, input logic [7:0] exp [12]);
        chk({name, "_len"}, 32'(cap_q.size()), 12);
        for (int i = 0; i < 12 && i < cap_q.size(); i++) chk(name, 32'(cap_q[i]), 32'(exp[i]));
    endtask

    logic [7:0] e1 [12] = '{8'h10, 8'h00, 8'h0C, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                            8'h03, 8'h00, 8'h00, 8'h00};
    logic [7:0] e2 [12] = '{8'h21, 8'h00, 8'h0C, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
                            8'h67, 8'h45, 8'h23, 8'h01};
    logic [7:0] e5 [12] = '{8'h44, 8'h00, 8'h0C, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
                            8'h88, 8'h77, 8'h66, 8'h55};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int n;
        reset_i         = 1'b1;
        cmd_valid_i     = 1'b0;
        cmd_opcode_i    = '0;
        cmd_a_i         = '0;
        cmd_b_i         = '0;
        s_axis_tdata_i  = '0;
        s_axis_tvalid_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();

        // 1: basic transaction with continuous ready
        cap_q.delete(); cap_cyc.delete();
        s = rsp_count;
        send_cmd(8'h10, 32'd5, 32'd3, 0);
        wait_tx_done();
        chk_cap("t1_bytes", e1);
        if (cap_cyc.size() == 12) begin
            chk("t1_first_latency", 32'(cap_cyc[0] - acc_cyc), 1);
            chk("t1_consecutive", 32'(cap_cyc[11] - cap_cyc[0]), 11);
        end
        send_rx(8'h08); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
        wait_rsp(s);
        chk("t1_rsp_data", rsp_seen_data, 32'h0000_0008);
        chk("t1_rsp_to", 32'(rsp_seen_to), 0);
        chk("t1_pulse_once", 32'(rsp_valid_o), 0);

        // 2: toggling back-pressure
        cap_q.delete(); cap_cyc.delete();
        tog_mode = 1;
        s = rsp_count;
        send_cmd(8'h21, 32'hDEAD_BEEF, 32'h0123_4567, 0);
        wait_tx_done();
        tog_mode = 0;
        chk_cap("t2_bytes", e2);
        if (cap_cyc.size() == 12) chk("t2_stalled", 32'(cap_cyc[11] - cap_cyc[0] > 11), 1);
        send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
        wait_rsp(s);
        chk("t2_rsp_data", rsp_seen_data, 32'h1234_5678);

        // 3: timeout after two response bytes
        s = rsp_count;
        send_cmd(8'h33, 32'h1, 32'h2, 0);
        wait_tx_done();
        send_rx(8'h9A); send_rx(8'hBC);
        wait_rsp(s);
        chk("t3_tmo_delay", 32'(rsp_cyc - last_rx_cyc), 16);
        chk("t3_rsp_to", 32'(rsp_seen_to), 1);
        chk("t3_rsp_data", rsp_seen_data, 0);
        chk("t3_busy_after", 32'(busy_o), 0);

        // 4: stray RX bytes in IDLE and SEND are dropped
        send_rx(8'hAA);
        chk("t4_idle_after_stray", 32'(busy_o), 0);
        s = rsp_count;
        send_cmd(8'h44, 32'h0, 32'h0, 0);
        send_rx(8'h55);
        wait_tx_done();
        send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
        wait_rsp(s);
        chk("t4_rsp_data", rsp_seen_data, 32'h0403_0201);
        chk("t4_rsp_to", 32'(rsp_seen_to), 0);

        // 5: reset mid-packet
        s = rsp_count;
        send_cmd(8'h77, 32'hCAFE_F00D, 32'h0BAD_0BAD, 0);
        n = 0;
        while (m_sent != 6 && n < 100) begin
            tick();
            n++;
        end
        chk("t5_reached_idx6", 32'(m_sent), 6);
        reset_i = 1'b1;
        #1;
        chk("t5_rst_tvalid", 32'(m_axis_tvalid_o), 0);
        chk("t5_rst_busy", 32'(busy_o), 0);
        chk("t5_rst_cmd_ready", 32'(cmd_ready_o), 1);
        tick(); tick();
        reset_i = 1'b0;
        tick();
        chk("t5_no_rsp", 32'(rsp_count - s), 0);
        cap_q.delete(); cap_cyc.delete();
        send_cmd(8'h44, 32'h1122_3344, 32'h5566_7788, 0);
        wait_tx_done();
        chk_cap("t5_bytes", e5);
        s = rsp_count;
        send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
        wait_rsp(s);
        chk("t5_rsp_data", rsp_seen_data, 32'h4433_2211);

        // 6: cmd_valid held through a transaction
        n = acc_count;
        s = rsp_count;
        send_cmd(8'h30, 32'h1, 32'h2, 1);
        wait_tx_done();
        chk("t6_not_ready_busy", 32'(cmd_ready_o), 0);
        send_rx(8'h03); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
        wait_rsp(s);
        cmd_valid_i = 1'b0;
        chk("t6_accepts", 32'(acc_count - n), 2);
        chk("t6_accept_on_rsp", 32'(acc_cyc - rsp_cyc), 0);
        s = rsp_count;
        wait_tx_done();
        send_rx(8'h03); send_rx(8'h00); send_rx(8'h00); send_rx(8'h00);
        wait_rsp(s);
        chk("t6_rsp2_data", rsp_seen_data, 32'h0000_0003);
        repeat (3) tick();
        chk("t6_accepts_final", 32'(acc_count - n), 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
